// File: rtl/date_pkg.sv
// Shared types and constants for the date-to-ASCII transmitter.
package date_pkg;

  typedef enum logic [3:0] {
    IDLE, CHK, CONV, YEAR, SEP1, MON, SEP2, DAY, FIN
  } state_t;

  localparam int unsigned BIN_W = 14;

  localparam logic [1:0] SEP_SLASH = 2'b00;
  localparam logic [1:0] SEP_DOT   = 2'b01;
  localparam logic [1:0] SEP_DASH  = 2'b10;
  localparam logic [1:0] SEP_BAD   = 2'b11;

  localparam logic [7:0] ASCII_SLASH = 8'h2F;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [13:0] YEAR_MAX  = 14'd9999;
  localparam logic [3:0]  MONTH_MAX = 4'd12;

  function automatic logic [7:0] sep_char(input logic [1:0] s);
    case (s)
      SEP_DOT:  return ASCII_DOT;
      SEP_DASH: return ASCII_DASH;
      default:  return ASCII_SLASH;
    endcase
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/date_bin2bcd.sv
// Iterative double-dabble: one input bit per cycle, result held until next go.
module date_bin2bcd
  import date_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        go,
  input  logic [13:0] bin,
  output logic [15:0] bcd,
  output logic        rdy
);

  logic [13:0] sr;
  logic [15:0] acc;
  logic [15:0] adj;
  logic [3:0]  cnt;

  always_comb begin
    adj = acc;
    for (int unsigned i = 0; i < 4; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
      rdy <= 1'b0;
    end else if (go) begin
      sr  <= bin;
      acc <= '0;
      cnt <= 4'(BIN_W);
      rdy <= 1'b0;
    end else if (cnt != '0) begin
      acc <= 16'({adj, sr[13]});
      sr  <= {sr[12:0], 1'b0};
      cnt <= cnt - 4'd1;
      rdy <= (cnt == 4'd1);
    end
  end

  assign bcd = acc;

endmodule

// File: rtl/date_tx.sv
// Validates a captured date and streams it as ASCII "Y<sep>M<sep>D" with
// leading zeros suppressed, over a valid/ready handshake.
module date_tx
  import date_pkg::*;
#(
  parameter int MAX_DAY = 30
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [13:0] year,
  input  logic [3:0]  month,
  input  logic [4:0]  day,
  input  logic [1:0]  sep,
  input  logic        ready,
  output logic [7:0]  out,
  output logic        out_valid,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [4:0] DAY_LIM = 5'(MAX_DAY);

  state_t      state, state_nxt;
  logic [13:0] year_r;
  logic [3:0]  mon_r;
  logic [4:0]  day_r;
  logic [1:0]  sep_r;
  logic [1:0]  idx, idx_nxt;
  logic        err_r, err_set;
  logic        go, rdy, bad;
  logic [15:0] ybcd;
  logic [3:0]  ydig;
  logic [1:0]  yfirst;
  logic [3:0]  m_tens, m_units, d_tens, d_units;
  logic [7:0]  ch;

  date_bin2bcd u_bcd (
    .clk (clk),
    .clr (clr),
    .go  (go),
    .bin (year_r),
    .bcd (ybcd),
    .rdy (rdy)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      idx    <= '0;
      err_r  <= 1'b0;
      year_r <= '0;
      mon_r  <= '0;
      day_r  <= '0;
      sep_r  <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      err_r <= err_set;
      if (state == IDLE && start) begin
        year_r <= year;
        mon_r  <= month;
        day_r  <= day;
        sep_r  <= sep;
      end
    end
  end

  assign bad = (year_r == '0) || (year_r > YEAR_MAX) ||
               (mon_r == '0)  || (mon_r > MONTH_MAX) ||
               (day_r == '0)  || (day_r > DAY_LIM)   ||
               (sep_r == SEP_BAD);

  assign m_tens  = mon_r / 4'd10;
  assign m_units = mon_r % 4'd10;
  assign d_tens  = 4'(day_r / 5'd10);
  assign d_units = 4'(day_r % 5'd10);

  // idx counts down through the remaining digits of the current field
  assign ydig   = ybcd[{idx, 2'b00} +: 4];
  assign yfirst = (ybcd[15:12] != '0) ? 2'd3 :
                  (ybcd[11:8]  != '0) ? 2'd2 :
                  (ybcd[7:4]   != '0) ? 2'd1 : 2'd0;

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    go        = 1'b0;
    err_set   = 1'b0;
    out_valid = 1'b0;
    ch        = 8'h00;
    case (state)
      IDLE: if (start) state_nxt = CHK;
      CHK: begin
        if (bad) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end else begin
          go        = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        if (rdy) begin
          state_nxt = YEAR;
          idx_nxt   = yfirst;
        end
      end
      YEAR: begin
        out_valid = 1'b1;
        ch        = digit_char(ydig);
        if (ready) begin
          if (idx == '0) state_nxt = SEP1;
          else           idx_nxt   = idx - 2'd1;
        end
      end
      SEP1: begin
        out_valid = 1'b1;
        ch        = sep_char(sep_r);
        if (ready) begin
          state_nxt = MON;
          idx_nxt   = {1'b0, m_tens != '0};
        end
      end
      MON: begin
        out_valid = 1'b1;
        ch        = digit_char(idx[0] ? m_tens : m_units);
        if (ready) begin
          if (idx == '0) state_nxt = SEP2;
          else           idx_nxt   = '0;
        end
      end
      SEP2: begin
        out_valid = 1'b1;
        ch        = sep_char(sep_r);
        if (ready) begin
          state_nxt = DAY;
          idx_nxt   = {1'b0, d_tens != '0};
        end
      end
      DAY: begin
        out_valid = 1'b1;
        ch        = digit_char(idx[0] ? d_tens : d_units);
        if (ready) begin
          if (idx == '0) state_nxt = FIN;
          else           idx_nxt   = '0;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign out  = out_valid ? ch : '0;
  assign busy = (state != IDLE);
  assign done = (state == FIN);
  assign err  = err_r;

endmodule

// File: doc/date_tx.md
DATE_TX -- requirements
Module: date_tx

Interface
REQ-001 Parameter: MAX_DAY, 30, highest day value accepted as valid.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 clr  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request to emit one date; sampled only in IDLE.
REQ-005 year  input  14  binary year; valid range 1..9999.
REQ-006 month  input  4  binary month; valid range 1..12.
REQ-007 day  input  5  binary day; valid range 1..MAX_DAY.
REQ-008 sep  input  2  separator select: 00 '/', 01 '.', 10 '-', 11 illegal.
REQ-009 ready  input  1  sink accepts the current character.
REQ-010 out  output  8  ASCII character.
REQ-011 out_valid  output  1  out holds a character.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse after the last character is accepted.
REQ-014 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-015 Start acceptance: start high in IDLE captures year, month, day and sep into internal registers. Later input changes have no effect on the current date.
REQ-016 Validation: the captured fields are checked in the cycle after capture.
- Failure conditions: year==0, year>9999, month==0, month>12, day==0, day>MAX_DAY, or sep==11.
- Response: err pulses for one cycle, the block returns to IDLE, and out_valid never rises.
REQ-017 States: IDLE, CHK, CONV, YEAR, SEP1, MON, SEP2, DAY, FIN.
REQ-018 CONV: converts the year to 4 BCD digits in exactly 14 cycles (one bit per cycle).
- Month and day are converted combinationally (tens = value/10, units = value%10).
REQ-019 Character stream: year digits, separator, month digits, separator, day digits.
- Digits are ASCII "0"+n.
- Leading zeros are suppressed in every field; units digits are always sent.
- Both separators are identical.
REQ-020 Handshake: one character transfers on a clk edge where out_valid && ready.
- out and out_valid stay stable until that transfer.
- ready is ignored while out_valid is low.
REQ-021 Throughput: with ready held high, one character transfers per cycle with no bubbles from YEAR through DAY.
REQ-022 Latency: with ready held high, the first out_valid appears 16 cycles after the start-accept edge (1 CHK + 14 CONV + 1).
REQ-023 FIN: done pulses for exactly one cycle in the cycle after the final day digit transfers; the block then returns to IDLE.
REQ-024 start during a busy state is ignored and not queued.
REQ-025 start in the IDLE cycle that directly follows a done or err pulse is accepted.
REQ-026 Output defaults: out=8'h00 whenever out_valid is low.

Reset
REQ-027 clr forces state IDLE and clears all registers.
REQ-028 Output values during and after reset: out=0, out_valid=0, busy=0, done=0, err=0.
REQ-029 clr asserted mid-operation aborts immediately; neither done nor err pulses for the aborted date.

Structure
REQ-030 Shared package date_pkg holds:
- state encodings;
- separator codes and their ASCII values ("/", ".", "-");
- ASCII "0";
- constants YEAR_MAX=9999 and MONTH_MAX=12.
REQ-031 Sub-module date_bin2bcd performs the iterative 14-bit double-dabble conversion.
- Ports: clk, clr, go, bin[13:0], bcd[15:0], rdy.
- rdy rises 14 cycles after go.
REQ-032 All state and output registers are clocked by clk and asynchronously reset by clr.

Verification
REQ-033 Basic date, ready high: year=2020, month=11, day=6, sep=00 -> "2020/11/6" (9 characters, 1 per cycle), then one done pulse.
REQ-034 Zero suppression: year=7, month=1, day=30, sep=01 -> "7.1.30", then done.
REQ-035 Invalid inputs, each run separately: month=13; day=31 with MAX_DAY=30; sep=11; year=0 -> each gives one err pulse, out_valid stays 0, busy returns to 0.
REQ-036 Backpressure: year=1999, month=12, day=25, sep=10, ready low for 3 cycles while on the '-' separator -> out stays "-" and stable, then the stream "1999-12-25" completes intact.
REQ-037 Reset mid-stream: clr pulsed after the 3rd character -> all outputs 0 next cycle, no done; a fresh start then produces the full correct string.
REQ-038 Start while busy: start pulsed during CONV with different fields -> only the first date is emitted, followed by exactly one done.
